negsub_arbiter: RTL and testbench
=================================

// Module: negsub_arbiter
// PURPOSE
// - Shares one W-bit two's-complement add/negate datapath between two requesters.
// - Each requester submits an operation with a valid/ready handshake.
// - A round-robin arbiter grants one requester at a time. A 3-state FSM sequences operand
//   capture, compute and result hand-off.
// - Sits between the acquisition/control logic and the 12-bit arithmetic path. Negation is
//   always formed as (B ^ all-ones) + 1.
// PARAMETERS
// - W  12  operand/result width in bits, signed two's complement
// PORTS
// - clk        in   1   system clock, rising edge
// - rst        in   1   reset, asynchronous, active-high
// - r0_valid   in   1   requester 0 has an operation pending
// - r0_ready   out  1   requester 0 operation accepted this cycle
// - r0_op      in   2   requester 0 opcode
// - r0_a       in   W   requester 0 operand A
// - r0_b       in   W   requester 0 operand B
// - r1_valid   in   1   requester 1 has an operation pending
// - r1_ready   out  1   requester 1 operation accepted this cycle
// - r1_op      in   2   requester 1 opcode
// - r1_a       in   W   requester 1 operand A
// - r1_b       in   W   requester 1 operand B
// - res_valid  out  1   result available
// - res_ready  in   1   consumer takes the result
// - res_data   out  W   result
// - res_id     out  1   requester that issued the result
// - res_ovf    out  1   signed overflow flag for the result
// BEHAVIOUR
// - Opcodes:
//   - 00 NEG = ~B+1
//   - 01 SUB = A+~B+1
//   - 10 ADD = A+B
//   - 11 ABS = B[W-1] ? ~B+1 : B
// - All sums are truncated to W bits; the carry-out is discarded.
// - res_ovf:
//   - NEG/ABS: set when B == 1<<(W-1); the result is then 1<<(W-1).
//   - ADD: set when A and B have the same sign and the result sign differs.
//   - SUB: set when A and B have different signs and the result sign differs from A.
// - FSM states: IDLE, EXEC, RESP.
// - IDLE:
//   - Arbitrate among valid requesters. If only one is valid, grant it.
//   - If both are valid, grant the one not served last (pointer `last`; reset value 1, so
//     r0 wins first).
//   - rX_ready is combinational: 1 only in IDLE, for the granted requester, when rX_valid=1.
//   - On acceptance, latch op, A, B and id; go to EXEC.
// - EXEC: compute the result and overflow from the latched operands, register them into
//   res_data/res_ovf, go to RESP. No handshake happens in EXEC.
// - RESP:
//   - res_valid=1. res_data, res_id and res_ovf hold stable until res_ready=1.
//   - On res_valid & res_ready: set last <= res_id, go to IDLE.
// - Latency: accept at edge t; res_valid is high from edge t+2.
// - Max throughput is one op per 3 cycles when res_ready is held at 1.
// - No new operation is accepted while in EXEC or RESP; r0_ready = r1_ready = 0 there.
// - rX_valid deasserting in the same cycle it is granted: no acceptance, FSM stays in IDLE.
// - Operand changes after acceptance have no effect on the in-flight operation.
// - Reset values (also on reset mid-operation; any in-flight op is dropped):
//   - state = IDLE, res_valid = 0, res_data = 0, res_id = 0, res_ovf = 0, last = 1.
//   - r0_ready = r1_ready = 0 while rst is high.
// - Starvation-free: with both requesters permanently valid, grants alternate 0,1,0,1...
// TESTING
// - Reset, then r0 NEG B=12'h001 -> res_data=12'hFFF, ovf=0, id=0, res_valid 2 cycles
//   after accept.
// - r1 SUB A=12'h005 B=12'h007 -> 12'hFFE, ovf=0, id=1.
//   r0 ADD A=12'h7FF B=12'h001 -> 12'h800, ovf=1.
// - NEG and ABS with B=12'h800 -> 12'h800, ovf=1.
//   ABS B=12'hFF6 -> 12'h00A, ovf=0.
//   SUB A=12'h800 B=12'h001 -> 12'h7FF, ovf=1.
// - Both valid continuously, res_ready=1, 6 ops -> ids 0,1,0,1,0,1.
//   Each ready pulse is 1 cycle, in IDLE only.
// - res_ready held 0 for 5 cycles in RESP -> outputs stable, both readys stay 0.
//   Release -> next grant on the following IDLE cycle.
// - Assert rst during EXEC and during RESP -> res_valid=0 immediately (async), state IDLE.
//   After release with both valid, r0 is granted first.

Source files
------------

// File: rtl/negsub_arbiter_if.sv
// Requester/result bundle for the shared add/negate datapath.
// The slave modport is the arbiter side and the master modport is the requester/consumer side.
interface negsub_arbiter_if #(
    parameter int W = 12
);
    logic         r0_valid;
    logic         r0_ready;
    logic [1:0]   r0_op;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;
    logic         r1_valid;
    logic         r1_ready;
    logic [1:0]   r1_op;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_id;
    logic         res_ovf;

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        input  r1_valid, r1_op, r1_a, r1_b,
        input  res_ready,
        output r0_ready, r1_ready,
        output res_valid, res_data, res_id, res_ovf
    );

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        output r1_valid, r1_op, r1_a, r1_b,
        output res_ready,
        input  r0_ready, r1_ready,
        input  res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/negsub_arbiter.sv
// Round-robin shared NEG/SUB/ADD/ABS unit. Result valid two edges after acceptance (one op per 3 cycles).
// Backpressure: the result holds until res_ready is high, and no request is accepted outside IDLE.
module negsub_arbiter #(
    parameter int W = 12
) (
    input  logic              clk,
    input  logic              rst,
    negsub_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         id;
    } req_t;

    localparam logic [1:0]   OP_NEG = 2'b00;
    localparam logic [1:0]   OP_SUB = 2'b01;
    localparam logic [1:0]   OP_ADD = 2'b10;
    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] MINV   = {1'b1, {(W-1){1'b0}}};

    state_t       state_q, state_d;
    req_t         req_q, req_d;
    logic         last_q;
    logic         grant;
    logic         accept;
    logic [W-1:0] neg_b, sum_sub, sum_add, calc;
    logic         calc_ovf;
    logic [W-1:0] res_data_q;
    logic         res_id_q, res_ovf_q;

    // With both requesters valid, the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (bus.r0_valid && bus.r1_valid) grant = ~last_q;
        else if (bus.r1_valid)            grant = 1'b1;
    end

    assign bus.r0_ready = (state_q == IDLE) && !rst && bus.r0_valid && !grant;
    assign bus.r1_ready = (state_q == IDLE) && !rst && bus.r1_valid &&  grant;
    assign accept       = bus.r0_ready || bus.r1_ready;

    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.id = grant;
            req_d.op = grant ? bus.r1_op : bus.r0_op;
            req_d.a  = grant ? bus.r1_a  : bus.r0_a;
            req_d.b  = grant ? bus.r1_b  : bus.r0_b;
        end
    end

    always_comb begin
        neg_b    = ~req_q.b + ONE;
        sum_sub  = req_q.a + ~req_q.b + ONE;
        sum_add  = req_q.a + req_q.b;
        calc     = neg_b;
        calc_ovf = (req_q.b == MINV);
        case (req_q.op)
            OP_NEG: begin
                calc     = neg_b;
                calc_ovf = (req_q.b == MINV);
            end
            OP_SUB: begin
                calc     = sum_sub;
                calc_ovf = (req_q.a[W-1] != req_q.b[W-1]) && (sum_sub[W-1] != req_q.a[W-1]);
            end
            OP_ADD: begin
                calc     = sum_add;
                calc_ovf = (req_q.a[W-1] == req_q.b[W-1]) && (sum_add[W-1] != req_q.a[W-1]);
            end
            default: begin
                calc     = req_q.b[W-1] ? neg_b : req_q.b;
                calc_ovf = (req_q.b == MINV);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            last_q     <= 1'b1;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (state_q == EXEC) begin
                res_data_q <= calc;
                res_ovf_q  <= calc_ovf;
                res_id_q   <= req_q.id;
            end
            if (state_q == RESP && bus.res_ready) last_q <= res_id_q;
        end
    end

    assign bus.res_valid = (state_q == RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_negsub_arbiter.sv
// Directed bench for negsub_arbiter: opcodes, overflow corners, arbitration order, stalls and reset.
module tb_negsub_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    negsub_arbiter_if #(.W(12)) bus ();

    negsub_arbiter #(.W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.r0_valid  = 1'b0;
        bus.r1_valid  = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    // Drives one request from requester id and walks it through EXEC and RESP.
    task automatic do_op(input string name, input logic id, input logic [1:0] op,
                         input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] ed, input logic eo);
        logic rdy;
        bus.r0_valid = ~id; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
        bus.r1_valid =  id; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
        bus.res_ready = 1'b0;
        #1;
        rdy = id ? bus.r1_ready : bus.r0_ready;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: ready=%b required 1", name, rdy);
        end
        tick();
        clear_inputs();
        bus.r0_a = ~a; bus.r0_b = ~b; bus.r1_a = ~a; bus.r1_b = ~b;
        bus.r0_op = ~op; bus.r1_op = ~op;
        #1;
        checks++;
        if ({bus.res_valid, bus.r0_ready, bus.r1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL %s exec: valid/r0rdy/r1rdy=%b required 000",
                     name, {bus.res_valid, bus.r0_ready, bus.r1_ready});
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id} !== {1'b1, ed, eo, id}) begin
            errors++;
            $display("FAIL %s result: valid=%b data=%h ovf=%b id=%b required 1 %h %b %b",
                     name, bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id, ed, eo, id);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: res_valid=%b required 0", name, bus.res_valid);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.r0_op = 2'b00; bus.r0_a = '0; bus.r0_b = '0;
        bus.r1_op = 2'b00; bus.r1_a = '0; bus.r1_b = '0;
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        #3;
        checks++;
        if ({bus.r0_ready, bus.r1_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_ovf} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: rdy0=%b rdy1=%b valid=%b data=%h id=%b ovf=%b required all 0",
                     bus.r0_ready, bus.r1_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_ovf);
        end
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ops();
        do_op("neg_1",      1'b0, 2'b00, 12'h000, 12'h001, 12'hFFF, 1'b0);
        do_op("sub_5_7",    1'b1, 2'b01, 12'h005, 12'h007, 12'hFFE, 1'b0);
        do_op("add_ovf",    1'b0, 2'b10, 12'h7FF, 12'h001, 12'h800, 1'b1);
        do_op("neg_min",    1'b1, 2'b00, 12'h123, 12'h800, 12'h800, 1'b1);
        do_op("abs_min",    1'b0, 2'b11, 12'h000, 12'h800, 12'h800, 1'b1);
        do_op("abs_neg10",  1'b1, 2'b11, 12'h000, 12'hFF6, 12'h00A, 1'b0);
        do_op("abs_pos",    1'b0, 2'b11, 12'h000, 12'h00A, 12'h00A, 1'b0);
        do_op("sub_ovf",    1'b1, 2'b01, 12'h800, 12'h001, 12'h7FF, 1'b1);
        do_op("add_neg",    1'b0, 2'b10, 12'hFFF, 12'hFFF, 12'hFFE, 1'b0);
    endtask

    task automatic test_valid_drop();
        bus.r0_valid = 1'b1;
        #1;
        checks++;
        if (bus.r0_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready_up: r0_ready=%b required 1", bus.r0_ready);
        end
        bus.r0_valid = 1'b0;
        #1;
        checks++;
        if (bus.r0_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready_down: r0_ready=%b required 0", bus.r0_ready);
        end
        tick();
        tick();
        bus.r1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.res_valid, bus.r1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL drop_still_idle: res_valid=%b r1_ready=%b required 0 1",
                     bus.res_valid, bus.r1_ready);
        end
        bus.r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        bus.r1_valid = 1'b1; bus.r1_op = 2'b10; bus.r1_a = 12'h100; bus.r1_b = 12'h023;
        #1;
        checks++;
        if (bus.r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: r1_ready=%b required 1", bus.r1_ready);
        end
        tick();
        tick();
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        bus.r1_a = 12'h555;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id, bus.r0_ready, bus.r1_ready}
                !== {1'b1, 12'h123, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h ovf=%b id=%b rdy0=%b rdy1=%b required 1 123 0 1 0 0",
                         i, bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id, bus.r0_ready, bus.r1_ready);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL stall_next_grant: r0_ready=%b r1_ready=%b required 1 0",
                     bus.r0_ready, bus.r1_ready);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        // Leave last=0 so that without the reset r1 would be next.
        do_op("pre_reset", 1'b0, 2'b00, 12'h000, 12'h002, 12'hFFE, 1'b0);
        bus.r0_valid = 1'b1; bus.r0_op = 2'b10; bus.r0_a = 12'h111; bus.r0_b = 12'h111;
        tick();
        clear_inputs();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec: res_valid=%b required 0", bus.res_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec_after: res_valid=%b required 0", bus.res_valid);
        end
        bus.r1_valid = 1'b1; bus.r1_op = 2'b10; bus.r1_a = 12'h222; bus.r1_b = 12'h111;
        tick();
        clear_inputs();
        tick();
        checks++;
        if ({bus.res_valid, bus.res_data} !== {1'b1, 12'h333}) begin
            errors++;
            $display("FAIL reset_pre_resp: valid=%b data=%h required 1 333", bus.res_valid, bus.res_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_ovf} !== 15'h0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b data=%h id=%b ovf=%b required 0 000 0 0",
                     bus.res_valid, bus.res_data, bus.res_id, bus.res_ovf);
        end
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready_low: r0_ready=%b r1_ready=%b required 0 0", bus.r0_ready, bus.r1_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant: r0_ready=%b r1_ready=%b required 1 0", bus.r0_ready, bus.r1_ready);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        logic [11:0] exp_d;
        bus.r0_op = 2'b10; bus.r0_a = 12'h001; bus.r0_b = 12'h002;
        bus.r1_op = 2'b01; bus.r1_a = 12'h00A; bus.r1_b = 12'h003;
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = i[0];
            exp_d  = exp_id ? 12'h007 : 12'h003;
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready} !== {~exp_id, exp_id}) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: r0_ready=%b r1_ready=%b required %b %b",
                         i, bus.r0_ready, bus.r1_ready, ~exp_id, exp_id);
            end
            tick();
            #1;
            checks++;
            if ({bus.r0_ready, bus.r1_ready, bus.res_valid} !== 3'b000) begin
                errors++;
                $display("FAIL b2b_exec[%0d]: rdy0=%b rdy1=%b valid=%b required 0 0 0",
                         i, bus.r0_ready, bus.r1_ready, bus.res_valid);
            end
            tick();
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_data, bus.r0_ready, bus.r1_ready}
                !== {1'b1, exp_id, exp_d, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: valid=%b id=%b data=%h rdy0=%b rdy1=%b required 1 %b %h 0 0",
                         i, bus.res_valid, bus.res_id, bus.res_data, bus.r0_ready, bus.r1_ready, exp_id, exp_d);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_valid_drop();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
